agu_pipe: RTL and testbench
===========================

# agu_pipe

Parametrised, pipelined x86 address generation unit. Accepts one memory-operand request per cycle (mode, base, index, scale, displacement, PC, segment descriptor, access size) and produces the effective offset and linear address one cycle later. It adds SIB scaling, full-width segment base addition, segment limit checking and line-crossing split generation, where a crossing access is emitted as two beats. It sits between decode/register read and the memory stage, with valid/ready handshakes on both sides.

## Interface

- AW, 32, address/operand width in bits
- LINE_BYTES, 16, cache line size in bytes (power of two, ≥ 8); LB = log2(LINE_BYTES)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid & in_ready
- in_mode  in  2  00 disp only; 01 base+disp; 10 base+(index<<scale)+disp; 11 PC-relative pc+disp
- in_base, in_index, in_disp, in_pc  in  AW  operands
- in_scale  in  2  index shift 0..3
- in_seg_base  in  AW  segment base
- in_seg_limit  in  AW  highest legal offset
- in_size  in  3  access bytes minus 1 (0..7)
- out_valid  out  1  beat present
- out_ready  in  1  beat consumed when out_valid & out_ready
- out_addr  out  AW  linear address of this beat
- out_ea  out  AW  effective offset (same on both beats)
- out_beat  out  1  0 first beat, 1 second beat of a split
- out_last  out  1  final beat of this request
- out_fault  out  1  limit violation; request is single-beat

## Operation

- ea = selected sum per in_mode, modulo 2^AW; (index<<scale) truncated to AW.
- seg = in_seg_base for modes 00–10; 0 for mode 11.
- linear = ea + seg, modulo 2^AW.
- Fault (modes 00–10 only): computed in AW+1 bits, fault = (ea + in_size) > in_seg_limit. Mode 11 never faults.
- Split: cross = (linear[LB-1:0] + in_size) ≥ LINE_BYTES, computed in LB+1 bits; a faulting request never splits.
- Beat 0: out_addr = linear. Beat 1: out_addr = {linear[AW-1:LB], LB'b0} + LINE_BYTES, modulo 2^AW.
- All arithmetic is computed from inputs at acceptance and captured in output registers; inputs need not be held after acceptance.
- FSM states: EMPTY, BEAT0, BEAT1.
  - EMPTY: accept → BEAT0.
  - BEAT0, out_ready & !split: accept new → BEAT0; else → EMPTY.
  - BEAT0, out_ready & split: → BEAT1; out_addr updates to beat-1 address.
  - BEAT1, out_ready: accept new → BEAT0; else → EMPTY.
  - No out_ready: hold state and all outputs stable.
- out_valid = (state ≠ EMPTY). out_beat = (state == BEAT1). out_last = BEAT1 | !split | fault.
- in_ready = !rst & (EMPTY | (out_valid & out_ready & out_last)), combinational.

## Timing

- Latency: acceptance in cycle N → beat 0 valid in cycle N+1.
- Throughput: one non-split request per cycle under continuous out_ready; a split request occupies two output cycles and blocks intake for one cycle.
- out_* stable while out_valid & !out_ready.
- Reset: state EMPTY; out_valid, out_addr, out_ea, out_beat, out_last, out_fault all 0; in_ready 0 while rst high.
- Reset during BEAT0/BEAT1: pending beats discarded, no beat 1 emitted; an input presented in the rst cycle is not accepted.
- Simultaneous last-beat consume and new accept: new request appears next cycle, no bubble.

## Test plan

- Mode 10, base 0x1000, index 0x20, scale 2, disp 0x4, seg_base 0x10000, limit 0xFFFFF, size 0 → one beat: ea 0x1084, addr 0x11084, last 1, fault 0.
- Split: mode 01, base 0x0E, disp 0, seg_base 0, size 3 → beat 0 addr 0x0E (beat 0, last 0), then beat 1 addr 0x10 (beat 1, last 1); in_ready low during beat 0.
- Limit fault: limit 0xFFFF, ea 0xFFFE, size 3 → single beat, fault 1, last 1, no beat 1; the same request with limit 0x10001 → fault 0.
- Wrap and mode 11: base 0xFFFFFFF0, disp 0x20, seg 0 → ea 0x10; mode 11, pc 0x400, disp 0xFFFFFFFC, seg_base 0x5000 → addr 0x3FC, no fault.
- Backpressure: 4 back-to-back requests, out_ready toggling 1,0,0,1,… → every beat delivered in order, outputs stable while stalled, no drop or duplication.
- Reset in BEAT0 of a split request → next cycle out_valid 0, all outputs 0, no beat 1 emitted; in_ready rises the cycle after rst falls.

Source files
------------

// File: rtl/agu_pipe.sv
// Pipelined x86 address generation unit: effective offset, segment-relative linear
// address, limit check and line-crossing split into two output beats.
module agu_pipe #(
  parameter int AW         = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_mode,
  input  logic [AW-1:0] in_base,
  input  logic [AW-1:0] in_index,
  input  logic [AW-1:0] in_disp,
  input  logic [AW-1:0] in_pc,
  input  logic [1:0]    in_scale,
  input  logic [AW-1:0] in_seg_base,
  input  logic [AW-1:0] in_seg_limit,
  input  logic [2:0]    in_size,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [AW-1:0] out_ea,
  output logic          out_beat,
  output logic          out_last,
  output logic          out_fault
);

  localparam int LB = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {EMPTY, BEAT0, BEAT1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [AW-1:0] ea_q, ea_d;
  logic          fault_q, fault_d;
  logic          beat_q, beat_d;
  logic          last_q, last_d;

  logic [AW-1:0] scaled, ea_calc, seg, linear_calc, addr1_calc;
  logic [AW:0]   ea_end;
  logic [LB:0]   off_end;
  logic          fault_calc, split_calc;
  logic          accept, consume;

  // Address arithmetic on the raw request; only the results are captured.
  always_comb begin
    scaled = in_index << in_scale;
    case (in_mode)
      2'b00:   ea_calc = in_disp;
      2'b01:   ea_calc = in_base + in_disp;
      2'b10:   ea_calc = in_base + scaled + in_disp;
      default: ea_calc = in_pc + in_disp;
    endcase
    seg         = (in_mode == 2'b11) ? '0 : in_seg_base;
    linear_calc = ea_calc + seg;
    ea_end      = {1'b0, ea_calc} + (AW+1)'(in_size);
    fault_calc  = (in_mode != 2'b11) && (ea_end > {1'b0, in_seg_limit});
    off_end     = {1'b0, linear_calc[LB-1:0]} + (LB+1)'(in_size);
    split_calc  = (off_end >= (LB+1)'(LINE_BYTES)) && !fault_calc;
    addr1_calc  = {linear_calc[AW-1:LB], {LB{1'b0}}} + AW'(LINE_BYTES);
  end

  assign out_valid = (state_q != EMPTY);
  assign out_addr  = addr_q;
  assign out_ea    = ea_q;
  assign out_beat  = beat_q;
  assign out_last  = last_q;
  assign out_fault = fault_q;

  assign consume  = out_valid && out_ready;
  assign in_ready = !rst && ((state_q == EMPTY) || (consume && last_q));
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    addr1_d = addr1_q;
    ea_d    = ea_q;
    fault_d = fault_q;
    beat_d  = beat_q;
    last_d  = last_q;
    if (accept) begin
      state_d = BEAT0;
      addr_d  = linear_calc;
      addr1_d = addr1_calc;
      ea_d    = ea_calc;
      fault_d = fault_calc;
      beat_d  = 1'b0;
      last_d  = !split_calc;
    end else if (consume) begin
      if (!last_q) begin
        // Second half of a line-crossing access starts at the next line.
        state_d = BEAT1;
        addr_d  = addr1_q;
        beat_d  = 1'b1;
        last_d  = 1'b1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      addr1_q <= '0;
      ea_q    <= '0;
      fault_q <= 1'b0;
      beat_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      addr1_q <= addr1_d;
      ea_q    <= ea_d;
      fault_q <= fault_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_agu_pipe.sv
// Scoreboard bench for agu_pipe: the driver queues expected beats on acceptance,
// a negedge monitor pops and compares every consumed beat and checks stall stability.
module tb_agu_pipe;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ea;
    logic        beat;
    logic        last;
    logic        fault;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = '0;
  logic [31:0] in_base = '0, in_index = '0, in_disp = '0, in_pc = '0;
  logic [1:0]  in_scale = '0;
  logic [31:0] in_seg_base = '0, in_seg_limit = '0;
  logic [2:0]  in_size = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_addr, out_ea;
  logic        out_beat, out_last, out_fault;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t exp_q[$];

  agu_pipe #(.AW(32), .LINE_BYTES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_base(in_base), .in_index(in_index),
    .in_disp(in_disp), .in_pc(in_pc), .in_scale(in_scale),
    .in_seg_base(in_seg_base), .in_seg_limit(in_seg_limit), .in_size(in_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_ea(out_ea), .out_beat(out_beat),
    .out_last(out_last), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares consumed beats and verifies outputs hold while stalled.
  logic        stall_seen = 1'b0;
  logic [31:0] s_addr, s_ea;
  logic        s_beat, s_last, s_fault;

  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_valid", out_valid, 1);
        check("stall_addr", out_addr, s_addr);
        check("stall_ea", out_ea, s_ea);
        check("stall_flags", {out_beat, out_last, out_fault}, {s_beat, s_last, s_fault});
      end
      stall_seen = out_valid && !out_ready;
      s_addr = out_addr; s_ea = out_ea;
      s_beat = out_beat; s_last = out_last; s_fault = out_fault;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_addr, 64'hDEAD_BEEF_0000_0000);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("addr", out_addr, e.addr);
          check("ea", out_ea, e.ea);
          check("beat", out_beat, e.beat);
          check("last", out_last, e.last);
          check("fault", out_fault, e.fault);
        end
      end
    end
  end

  // Presents one request and queues its expected beats once it is accepted.
  task automatic issue(input logic [1:0] m, input logic [31:0] b, input logic [31:0] idx,
                       input logic [1:0] sc, input logic [31:0] d, input logic [31:0] pc,
                       input logic [31:0] sb, input logic [31:0] lim, input logic [2:0] sz,
                       input logic [31:0] e_ea, input logic [31:0] e_addr,
                       input logic [31:0] e_addr1, input logic e_fault, input logic e_split);
    bit acc = 0;
    in_mode = m; in_base = b; in_index = idx; in_scale = sc; in_disp = d; in_pc = pc;
    in_seg_base = sb; in_seg_limit = lim; in_size = sz; in_valid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        exp_q.push_back('{addr: e_addr, ea: e_ea, beat: 1'b0, last: !e_split, fault: e_fault});
        if (e_split)
          exp_q.push_back('{addr: e_addr1, ea: e_ea, beat: 1'b1, last: 1'b1, fault: 1'b0});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_outs", {out_addr, out_ea, out_beat, out_last, out_fault}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SIB scaling with segment base.
    issue(2'b10, 32'h1000, 32'h20, 2'd2, 32'h4, 0, 32'h10000, 32'hFFFFF, 3'd0,
          32'h1084, 32'h11084, 0, 1'b0, 1'b0);
    // Line-crossing split; intake must be blocked while beat 0 is presented.
    issue(2'b01, 32'h0E, 0, 2'd0, 0, 0, 0, 32'hFFFF_FFFF, 3'd3,
          32'h0E, 32'h0E, 32'h10, 1'b0, 1'b1);
    @(negedge clk);
    check("split_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    // Limit fault suppresses the split; relaxing the limit restores it.
    issue(2'b01, 32'hFFFE, 0, 2'd0, 0, 0, 0, 32'hFFFF, 3'd3,
          32'hFFFE, 32'hFFFE, 0, 1'b1, 1'b0);
    issue(2'b01, 32'hFFFE, 0, 2'd0, 0, 0, 0, 32'h10001, 3'd3,
          32'hFFFE, 32'hFFFE, 32'h10000, 1'b0, 1'b1);
    // End of access exactly at the limit does not fault.
    issue(2'b00, 0, 0, 2'd0, 32'hFFFC, 0, 0, 32'hFFFF, 3'd3,
          32'hFFFC, 32'hFFFC, 0, 1'b0, 1'b0);
    // Disp-only mode faulting, with segment base added to the address.
    issue(2'b00, 0, 0, 2'd0, 32'h1234, 0, 32'h100, 32'h1000, 3'd1,
          32'h1234, 32'h1334, 0, 1'b1, 1'b0);
    // Line-offset boundary: last byte 15 stays, last byte 16 splits.
    issue(2'b00, 0, 0, 2'd0, 32'h0D, 0, 0, 32'hFFFF_FFFF, 3'd2,
          32'h0D, 32'h0D, 0, 1'b0, 1'b0);
    issue(2'b00, 0, 0, 2'd0, 32'h0D, 0, 0, 32'hFFFF_FFFF, 3'd3,
          32'h0D, 32'h0D, 32'h10, 1'b0, 1'b1);
    // Offset wrap, then PC-relative ignoring segment and limit.
    issue(2'b01, 32'hFFFF_FFF0, 0, 2'd0, 32'h20, 0, 0, 32'hFFFF_FFFF, 3'd0,
          32'h10, 32'h10, 0, 1'b0, 1'b0);
    issue(2'b11, 0, 0, 2'd0, 32'hFFFF_FFFC, 32'h400, 32'h5000, 0, 3'd0,
          32'h3FC, 32'h3FC, 0, 1'b0, 1'b0);
    drain();

    // Back-to-back requests against out_ready pattern 1,0,0,1.
    fork
      begin
        issue(2'b01, 32'h100, 0, 2'd0, 32'h20, 0, 32'h1000, 32'hFFFF, 3'd7,
              32'h120, 32'h1120, 0, 1'b0, 1'b0);
        issue(2'b01, 32'h200, 0, 2'd0, 32'h20, 0, 32'h1000, 32'hFFFF, 3'd7,
              32'h220, 32'h1220, 0, 1'b0, 1'b0);
        issue(2'b01, 32'h30C, 0, 2'd0, 32'h20, 0, 32'h1000, 32'hFFFF, 3'd7,
              32'h32C, 32'h132C, 32'h1330, 1'b0, 1'b1);
        issue(2'b01, 32'h400, 0, 2'd0, 32'h20, 0, 32'h1000, 32'hFFFF, 3'd7,
              32'h420, 32'h1420, 0, 1'b0, 1'b0);
      end
      begin
        logic [3:0] pat;
        pat = 4'b1001;
        for (int c = 0; c < 24; c++) begin
          out_ready = pat[3 - (c % 4)];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while beat 0 of a split is pending.
    out_ready = 1'b0;
    issue(2'b00, 0, 0, 2'd0, 32'h1E, 0, 0, 32'hFFFF_FFFF, 3'd7,
          32'h1E, 32'h1E, 32'h20, 1'b0, 1'b1);
    @(negedge clk);
    check("pre_rst_beat0", {out_valid, out_beat, out_addr}, {1'b1, 1'b0, 32'h1E});
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    in_mode = 2'b00; in_disp = 32'h40; in_size = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_during_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_outs", {out_addr, out_ea, out_beat, out_last, out_fault}, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("no_beat1_after_rst", out_valid, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
